// File: rtl/fifo_stream_writer.sv
// rtl/fifo_stream_writer.sv - valid/ready stream to FIFO write port with 2-entry skid buffer
// Optional stall counter enabled by FSW_STALL_CNT_EN.
module fifo_stream_writer #(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             w_rst,
  input  logic             s_valid,
  input  logic [DW-1:0]    s_data,
  input  logic             s_last,
  output logic             s_ready,
  input  logic             fifo_full,
  output logic             fifo_w_en,
  output logic [DW-1:0]    fifo_data,
  output logic             in_frame,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {IDLE, FRAME} state_t;

  state_t        state;
  logic [DW-1:0] data0, data1;
  logic          last0, last1;
  logic [1:0]    count, count_next;
  logic          accept, pop;

  assign accept    = s_valid & s_ready;
  assign pop       = (count != 2'd0) & ~fifo_full;
  assign fifo_w_en = pop;
  assign fifo_data = data0;
  assign in_frame  = (state == FRAME);

  always_comb begin
    count_next = count;
    if (accept && !pop)
      count_next = count + 2'd1;
    else if (!accept && pop)
      count_next = count - 2'd1;
  end

  // Entry 0 is always the head; a pop shifts entry 1 forward, and an incoming
  // word lands in whichever slot is first free after that shift.
  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      data0 <= '0;
      last0 <= 1'b0;
      data1 <= '0;
      last1 <= 1'b0;
    end else begin
      if (pop) begin
        data0 <= data1;
        last0 <= last1;
      end
      if (accept) begin
        if (count == 2'd0 || (count == 2'd1 && pop)) begin
          data0 <= s_data;
          last0 <= s_last;
        end else begin
          data1 <= s_data;
          last1 <= s_last;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      count     <= 2'd0;
      s_ready   <= 1'b0;
      state     <= IDLE;
      frame_cnt <= '0;
    end else begin
      count   <= count_next;
      s_ready <= (count_next <= 2'd1);
      if (pop && last0)
        frame_cnt <= frame_cnt + 1'b1;
      case (state)
        IDLE:    if (accept && !s_last) state <= FRAME;
        FRAME:   if (accept && s_last)  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FSW_STALL_CNT_EN
  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst)
      stall_cnt <= '0;
    else if (count != 2'd0 && fifo_full && stall_cnt != {CNT_W{1'b1}})
      stall_cnt <= stall_cnt + 1'b1;
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_writer.sv
// tb/tb_fifo_stream_writer.sv - randomized and directed bench for fifo_stream_writer
module tb_fifo_stream_writer;
  localparam int DW    = 8;
  localparam int CNT_W = 16;

  typedef logic [DW:0] ent_t;

  logic             clk = 1'b0;
  logic             w_rst;
  logic             s_valid;
  logic [DW-1:0]    s_data;
  logic             s_last;
  logic             s_ready;
  logic             fifo_full;
  logic             fifo_w_en;
  logic [DW-1:0]    fifo_data;
  logic             in_frame;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] stall_cnt;

  fifo_stream_writer #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .w_rst     (w_rst),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .fifo_full (fifo_full),
    .fifo_w_en (fifo_w_en),
    .fifo_data (fifo_data),
    .in_frame  (in_frame),
    .frame_cnt (frame_cnt),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  ent_t             mq[$];
  logic [DW-1:0]    seen[$];
  bit               m_ready;
  bit               m_inframe;
  logic [CNT_W-1:0] m_frames;
  logic [CNT_W-1:0] m_stall;
  bit               last_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_ready   = 1'b0;
    m_inframe = 1'b0;
    m_frames  = '0;
    m_stall   = '0;
  endtask

  task automatic do_reset();
    w_rst = 1'b1;
    #1;
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_w_en", 32'(fifo_w_en), 32'd0);
    check("rst_data", 32'(fifo_data), 32'd0);
    check("rst_in_frame", 32'(in_frame), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    w_rst = 1'b0;
  endtask

  // One clock: drive inputs, compare every output against the model mid-cycle,
  // then advance the model over the following rising edge.
  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit l, input bit f);
    bit   exp_wen, acc, pop;
    ent_t h;
    s_valid   = v;
    s_data    = d;
    s_last    = l;
    fifo_full = f;
    @(negedge clk);
    exp_wen = (mq.size() != 0) && !f;
    check("s_ready", 32'(s_ready), 32'(m_ready));
    check("w_en", 32'(fifo_w_en), 32'(exp_wen));
    if (exp_wen) begin
      h = mq[0];
      check("data", 32'(fifo_data), 32'(h[DW:1]));
    end
    check("in_frame", 32'(in_frame), 32'(m_inframe));
    check("frame_cnt", 32'(frame_cnt), 32'(m_frames));
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    if (fifo_w_en) seen.push_back(fifo_data);
    acc = v && m_ready;
    pop = exp_wen;
    @(posedge clk);
    #1;
`ifdef FSW_STALL_CNT_EN
    if (mq.size() != 0 && f && m_stall != {CNT_W{1'b1}}) m_stall = m_stall + 1'b1;
`endif
    if (pop) begin
      h = mq.pop_front();
      if (h[0]) m_frames = m_frames + 1'b1;
    end
    if (acc) begin
      mq.push_back({d, l});
      m_inframe = !l;
    end
    m_ready  = (mq.size() <= 1);
    last_acc = acc;
  endtask

  initial begin
    logic [CNT_W-1:0] f0;
    int               idx;
    bit               pend, rv, rl, rf;
    logic [DW-1:0]    rd;

    s_valid = 1'b0; s_data = '0; s_last = 1'b0; fifo_full = 1'b0;
    do_reset();
    cycle(0, 8'h00, 0, 0);

    // 5-word frame with no backpressure
    seen.delete();
    f0 = m_frames;
    for (int i = 0; i < 5; i++) cycle(1, 8'(8'h11 + i), i == 4, 0);
    for (int i = 0; i < 2; i++) cycle(0, 8'h00, 0, 0);
    check("stream_len", 32'(seen.size()), 32'd5);
    for (int i = 0; i < 5 && i < seen.size(); i++)
      check("stream_word", 32'(seen[i]), 32'(8'h11 + i));
    check("stream_frames", 32'(frame_cnt), 32'(f0 + 1'b1));

    // 8-word frame with fifo_full high for 6 cycles
    seen.delete();
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      cycle(idx < 8, 8'(8'h30 + idx), idx == 7, (c >= 2 && c < 8));
      if (last_acc) idx++;
    end
    check("bp_len", 32'(seen.size()), 32'd8);
    for (int i = 0; i < 8 && i < seen.size(); i++)
      check("bp_word", 32'(seen[i]), 32'(8'h30 + i));

    // three 1-word frames back to back
    f0 = m_frames;
    for (int i = 0; i < 3; i++) cycle(1, 8'(8'h40 + i), 1, 0);
    for (int i = 0; i < 2; i++) cycle(0, 8'h00, 0, 0);
    check("one_word_frames", 32'(frame_cnt), 32'(f0 + 2'd3));

    // reset with two words buffered
    cycle(1, 8'h51, 0, 1);
    cycle(1, 8'h52, 0, 1);
    cycle(1, 8'h53, 0, 1);
    do_reset();
    seen.delete();
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 0, 0);
    check("no_stale_write", 32'(seen.size()), 32'd0);

    // stall counter: one word held for 10 full cycles
    do_reset();
    cycle(0, 8'h00, 0, 0);
    cycle(1, 8'h61, 1, 1);
    for (int i = 0; i < 10; i++) cycle(0, 8'h00, 0, 1);
`ifdef FSW_STALL_CNT_EN
    check("stall_10", 32'(stall_cnt), 32'd10);
`else
    check("stall_off", 32'(stall_cnt), 32'd0);
`endif
    cycle(0, 8'h00, 0, 0);

    // random traffic; upstream holds a word until it is taken
    pend = 1'b0; rv = 1'b0; rd = '0; rl = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!pend) begin
        rv = ($urandom_range(0, 3) != 0);
        rd = 8'($urandom);
        rl = ($urandom_range(0, 4) == 0);
      end
      rf = ($urandom_range(0, 2) == 0);
      cycle(rv, rd, rl, rf);
      pend = rv && !last_acc;
    end
    for (int i = 0; i < 4; i++) cycle(0, 8'h00, 0, 0);
    check("drained", 32'(mq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
